e_mdu: RTL and testbench
========================

Name: e_mdu

Overview:
- Multiply/divide unit of the Execute stage. Consumes operand values and mdOp from the D/E pipeline register after forwarding muxes.
- Owns the architectural HI/LO registers.
- Models multi-cycle MIPS mult/multu/div/divu with a busy counter for the hazard unit; mfhi/mflo/mthi/mtlo access HI/LO directly.
- A pending interrupt/exception (i_Req) suppresses any new HI/LO side effect from the instruction currently in E.

Parameters:
- MULT_CYCLES, 5, busy duration of mult/multu, in cycles (>=1).
- DIV_CYCLES, 10, busy duration of div/divu, in cycles (>=1).

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_Req  in  1  interrupt/exception taken this cycle; E-stage instruction is cancelled
- i_mdOp  in  4  operation code (MD_* constants)
- i_A  in  32  rs value (forwarded)
- i_B  in  32  rt value (forwarded)
- o_start  out  1  combinational; 1 when i_mdOp is MULT/MULTU/DIV/DIVU
- o_busy  out  1  registered; 1 while an operation is in flight
- o_result  out  32  combinational; HI when MFHI, LO when MFLO, else 0
- o_HI  out  32  architectural HI
- o_LO  out  32  architectural LO

Behaviour:
- Reset: clock i_clk; reset i_reset, synchronous, active-high. Sets HI, LO, hi_tmp, lo_tmp and cnt to 0, o_busy to 0 and the state to IDLE. Reset has priority over everything, including mid-operation.
- States:
  - IDLE (o_busy=0).
  - BUSY (o_busy=1; cnt holds the remaining cycles).
- IDLE -> BUSY: at a posedge with o_start=1, i_Req=0 and no reset.
  - cnt <= MULT_CYCLES for mult/multu, DIV_CYCLES for div/divu.
  - hi_tmp/lo_tmp <= result computed from i_A/i_B at that edge.
- BUSY, each posedge:
  - cnt <= cnt-1.
  - When cnt==1: HI<=hi_tmp, LO<=lo_tmp, go to IDLE.
  - o_busy is therefore high for exactly N cycles after the start edge.
  - New HI/LO values are visible on the edge that drops o_busy.
- Arithmetic:
  - MULT: {HI,LO} = signed64(A)*signed64(B).
  - MULTU: unsigned 64-bit product.
  - DIV: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - DIVU: unsigned quotient and remainder.
  - Divide by zero (B==0): hi_tmp/lo_tmp <= current HI/LO, so HI/LO are unchanged. Full DIV_CYCLES busy timing still applies.
- MTHI/MTLO: HI/LO <= i_A at the posedge when i_Req=0 and state is IDLE.
- MFHI/MFLO: combinational read of the architectural HI/LO; never reads the tmp registers.
- Hazard contract: the hazard unit stalls any MD instruction in D while (o_start | o_busy).
  - o_start or MTHI/MTLO while BUSY is a contract violation. The block ignores it: no restart, no write.
- i_Req:
  - Blocks the start and MTHI/MTLO of the instruction in E on that edge.
  - Does NOT abort an in-flight operation, which belongs to an older committed instruction. It completes and writes HI/LO normally.
- MD_NONE or unknown op: no state change, o_result=0.

Decomposition:
- Shared definitions file (def.v): MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MFHI=5, MD_MFLO=6, MD_MTHI=7, MD_MTLO=8.
- Default latencies also go in def.v.
- Single module. The arithmetic is a combinational block inside it; no sub-module warranted.

Test Plan:
- Reset, then MULT with A=0xFFFFFFFF, B=2 for one cycle: o_busy=1 for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. o_busy falls on the same edge HI/LO update.
- MULTU with the same operands: HI=0x00000001, LO=0xFFFFFFFE after 5 cycles. DIVU 7/2: LO=3, HI=1 after 10 cycles.
- DIV with A=0xFFFFFFF9 (-7), B=2: LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV with B=0, HI/LO previously 0x11/0x22: busy for 10 cycles, HI/LO stay 0x11/0x22.
- MTHI A=0xDEADBEEF, then MFHI: o_result=0xDEADBEEF. MTLO with i_Req=1: LO unchanged.
- MULT with i_Req=1 on its start edge: o_busy stays 0, HI/LO unchanged. In-flight DIV with i_Req pulsed at cycle 3: completes at cycle 10 with correct result.
- i_reset at cycle 2 of a MULT: next edge o_busy=0, HI=LO=0, and no late write occurs.

Source files
------------

// File: rtl/e_mdu_pkg.sv
// ----------------------------------------------------------------------------
// e_mdu_pkg
//   Shared definitions for the Execute-stage multiply/divide unit:
//   mdOp operation codes, default latencies, the FSM state type and a
//   helper that classifies the multi-cycle operations.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package e_mdu_pkg;

  // mdOp encodings
  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  // Default busy latencies, in cycles
  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_t;

  // True for the operations that occupy the unit for several cycles
  function automatic logic md_is_start(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) ||
           (op == MD_DIV)  || (op == MD_DIVU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/e_mdu_if.sv
// ----------------------------------------------------------------------------
// e_mdu_if
//   Operand/result bundle between the Execute stage and the MDU.
//   slave  : the MDU itself
//   master : the pipeline (or a testbench) driving operands and reading
//            start/busy/result/HI/LO
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface e_mdu_if;
  logic        i_Req;     // E-stage instruction cancelled this cycle
  logic [3:0]  i_mdOp;    // operation code
  logic [31:0] i_A;       // rs value
  logic [31:0] i_B;       // rt value
  logic        o_start;   // multi-cycle op presented this cycle
  logic        o_busy;    // operation in flight
  logic [31:0] o_result;  // mfhi/mflo read data
  logic [31:0] o_HI;      // architectural HI
  logic [31:0] o_LO;      // architectural LO

  modport slave (
    input  i_Req, i_mdOp, i_A, i_B,
    output o_start, o_busy, o_result, o_HI, o_LO
  );

  modport master (
    output i_Req, i_mdOp, i_A, i_B,
    input  o_start, o_busy, o_result, o_HI, o_LO
  );
endinterface

`default_nettype wire

// File: rtl/e_mdu.sv
// ----------------------------------------------------------------------------
// e_mdu
//   Execute-stage multiply/divide unit owning the HI/LO registers.
//   The result of mult/multu/div/divu is computed on the start edge into
//   hi_tmp/lo_tmp and committed to HI/LO after MULT_CYCLES / DIV_CYCLES,
//   modelling the architectural latency seen by the hazard unit.
//   Ports:
//     i_clk   : clock
//     i_reset : synchronous, active-high reset
//     md      : e_mdu_if.slave (i_Req, i_mdOp, i_A, i_B ->
//               o_start, o_busy, o_result, o_HI, o_LO)
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  wire logic i_clk,
  input  wire logic i_reset,
  e_mdu_if.slave    md
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_t          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic [31:0]        hi_tmp_q, hi_tmp_d, lo_tmp_q, lo_tmp_d;

  // --------------------------------------------------------------------------
  // Arithmetic
  // --------------------------------------------------------------------------
  logic [63:0] smul, umul;
  logic [31:0] res_hi, res_lo;
  logic [31:0] abs_a, abs_b, divisor, uq, ur, sq, sr;
  logic        div_zero;

  assign smul     = $signed({{32{md.i_A[31]}}, md.i_A}) * $signed({{32{md.i_B[31]}}, md.i_B});
  assign umul     = {32'd0, md.i_A} * {32'd0, md.i_B};
  assign div_zero = (md.i_B == 32'd0);

  always_comb begin
    abs_a = md.i_A;
    abs_b = md.i_B;
    if (md.i_mdOp == MD_DIV) begin
      // Signed divide is done on magnitudes so 0x80000000 / -1 wraps
      // cleanly to 0x80000000 instead of relying on simulator overflow rules.
      abs_a = md.i_A[31] ? (~md.i_A + 32'd1) : md.i_A;
      abs_b = md.i_B[31] ? (~md.i_B + 32'd1) : md.i_B;
    end
    // Keep the divider defined on B==0; its output is discarded then.
    divisor = div_zero ? 32'd1 : abs_b;
    uq      = abs_a / divisor;
    ur      = abs_a % divisor;
    sq      = (md.i_A[31] ^ md.i_B[31]) ? (~uq + 32'd1) : uq;
    sr      = md.i_A[31] ? (~ur + 32'd1) : ur;

    res_hi = hi_q;
    res_lo = lo_q;
    case (md.i_mdOp)
      MD_MULT:  {res_hi, res_lo} = smul;
      MD_MULTU: {res_hi, res_lo} = umul;
      MD_DIV:   if (!div_zero) begin res_hi = sr; res_lo = sq; end
      MD_DIVU:  if (!div_zero) begin res_hi = ur; res_lo = uq; end
      default:  ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_tmp_d = hi_tmp_q;
    lo_tmp_d = lo_tmp_q;
    case (state_q)
      ST_IDLE: begin
        if (!md.i_Req) begin
          if (md_is_start(md.i_mdOp)) begin
            state_d  = ST_BUSY;
            cnt_d    = ((md.i_mdOp == MD_MULT) || (md.i_mdOp == MD_MULTU))
                       ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            hi_tmp_d = res_hi;
            lo_tmp_d = res_lo;
          end else if (md.i_mdOp == MD_MTHI) begin
            hi_d = md.i_A;
          end else if (md.i_mdOp == MD_MTLO) begin
            lo_d = md.i_A;
          end
        end
      end
      ST_BUSY: begin
        // In-flight work belongs to an older committed instruction, so
        // i_Req does not cancel it; new requests here are ignored.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          hi_d    = hi_tmp_q;
          lo_d    = lo_tmp_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      hi_tmp_q <= '0;
      lo_tmp_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_tmp_q <= hi_tmp_d;
      lo_tmp_q <= lo_tmp_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign md.o_start  = md_is_start(md.i_mdOp);
  assign md.o_busy   = (state_q == ST_BUSY);
  assign md.o_HI     = hi_q;
  assign md.o_LO     = lo_q;
  assign md.o_result = (md.i_mdOp == MD_MFHI) ? hi_q :
                       (md.i_mdOp == MD_MFLO) ? lo_q : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_e_mdu.sv
// ----------------------------------------------------------------------------
// tb_e_mdu
//   Directed self-checking bench for e_mdu with hand-computed expectations.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_e_mdu;
  import e_mdu_pkg::*;

  logic i_clk;
  logic i_reset;
  int   n_cmp;
  int   n_err;

  e_mdu_if mdu_if ();

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .md      (mdu_if.slave)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present an op for exactly one posedge, then return to MD_NONE.
  task automatic issue(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic req);
    @(negedge i_clk);
    mdu_if.i_mdOp = op;
    mdu_if.i_A    = a;
    mdu_if.i_B    = b;
    mdu_if.i_Req  = req;
    @(posedge i_clk);
    #1;
    mdu_if.i_mdOp = MD_NONE;
    mdu_if.i_Req  = 1'b0;
  endtask

  // Count negedges with o_busy high (bounded), then check HI/LO.
  task automatic wait_done(input string tag, input int exp_n,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    n = 0;
    @(negedge i_clk);
    while (mdu_if.o_busy && n < 100) begin
      n++;
      @(negedge i_clk);
    end
    chk({tag, "_busy_cycles"}, 32'(n), 32'(exp_n));
    chk({tag, "_hi"}, mdu_if.o_HI, exp_hi);
    chk({tag, "_lo"}, mdu_if.o_LO, exp_lo);
  endtask

  initial begin
    int n;
    n_cmp = 0;
    n_err = 0;
    i_reset       = 1'b1;
    mdu_if.i_Req  = 1'b0;
    mdu_if.i_mdOp = MD_NONE;
    mdu_if.i_A    = 32'd0;
    mdu_if.i_B    = 32'd0;
    repeat (3) @(posedge i_clk);
    #1 i_reset = 1'b0;

    // Reset state
    @(negedge i_clk);
    chk("rst_busy", {31'd0, mdu_if.o_busy}, 32'd0);
    chk("rst_hi", mdu_if.o_HI, 32'd0);
    chk("rst_lo", mdu_if.o_LO, 32'd0);
    chk("rst_result", mdu_if.o_result, 32'd0);

    // o_start decode
    mdu_if.i_mdOp = MD_MULT;
    #1 chk("start_mult", {31'd0, mdu_if.o_start}, 32'd1);
    mdu_if.i_mdOp = MD_MTHI;
    #1 chk("start_mthi", {31'd0, mdu_if.o_start}, 32'd0);
    mdu_if.i_mdOp = MD_NONE;

    // MULT -1 * 2; HI/LO hold old value while busy
    issue(MD_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0);
    @(negedge i_clk);
    chk("mult_busy_early", {31'd0, mdu_if.o_busy}, 32'd1);
    chk("mult_lo_early", mdu_if.o_LO, 32'd0);
    wait_done("mult", 4, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

    issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_done("multu", 5, 32'h0000_0001, 32'hFFFF_FFFE);

    issue(MD_DIVU, 32'd7, 32'd2, 1'b0);
    wait_done("divu", 10, 32'd1, 32'd3);

    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_done("div_neg", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_done("div_ovf", 10, 32'd0, 32'h8000_0000);

    // Divide by zero keeps HI/LO
    issue(MD_MTHI, 32'h11, 32'd0, 1'b0);
    issue(MD_MTLO, 32'h22, 32'd0, 1'b0);
    issue(MD_DIV, 32'd5, 32'd0, 1'b0);
    wait_done("div_zero", 10, 32'h11, 32'h22);

    // MTHI then MFHI / MFLO reads
    issue(MD_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b0);
    @(negedge i_clk);
    mdu_if.i_mdOp = MD_MFHI;
    #1 chk("mfhi", mdu_if.o_result, 32'hDEAD_BEEF);
    mdu_if.i_mdOp = MD_MFLO;
    #1 chk("mflo", mdu_if.o_result, 32'h22);
    mdu_if.i_mdOp = MD_NONE;

    // MTLO cancelled by i_Req
    issue(MD_MTLO, 32'h1234_5678, 32'd0, 1'b1);
    @(negedge i_clk);
    chk("mtlo_req_lo", mdu_if.o_LO, 32'h22);

    // MULT cancelled by i_Req
    issue(MD_MULT, 32'd3, 32'd4, 1'b1);
    @(negedge i_clk);
    chk("mult_req_busy", {31'd0, mdu_if.o_busy}, 32'd0);
    chk("mult_req_hi", mdu_if.o_HI, 32'hDEAD_BEEF);
    chk("mult_req_lo", mdu_if.o_LO, 32'h22);

    // In-flight DIV 100/7 with i_Req pulse at cycle 3 and an illegal
    // MULT/MTLO presented mid-flight; neither may disturb it.
    issue(MD_DIV, 32'd100, 32'd7, 1'b0);
    n = 0;
    @(negedge i_clk);
    while (mdu_if.o_busy && n < 100) begin
      n++;
      mdu_if.i_Req  = (n == 3);
      mdu_if.i_mdOp = (n == 5) ? MD_MULT : (n == 7) ? MD_MTLO : MD_NONE;
      mdu_if.i_A    = 32'h5555_5555;
      mdu_if.i_B    = 32'd3;
      @(negedge i_clk);
    end
    mdu_if.i_Req  = 1'b0;
    mdu_if.i_mdOp = MD_NONE;
    chk("div_inflight_busy_cycles", 32'(n), 32'd10);
    chk("div_inflight_hi", mdu_if.o_HI, 32'd2);
    chk("div_inflight_lo", mdu_if.o_LO, 32'd14);
    @(negedge i_clk);
    chk("div_inflight_idle", {31'd0, mdu_if.o_busy}, 32'd0);

    // Reset mid-MULT: no late write afterwards
    issue(MD_MULT, 32'd3, 32'd4, 1'b0);
    @(negedge i_clk);
    i_reset = 1'b1;
    @(posedge i_clk);
    #1 i_reset = 1'b0;
    @(negedge i_clk);
    chk("rst_mid_busy", {31'd0, mdu_if.o_busy}, 32'd0);
    chk("rst_mid_hi", mdu_if.o_HI, 32'd0);
    chk("rst_mid_lo", mdu_if.o_LO, 32'd0);
    repeat (8) @(negedge i_clk);
    chk("rst_mid_late_lo", mdu_if.o_LO, 32'd0);
    chk("rst_mid_late_busy", {31'd0, mdu_if.o_busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
